// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving the select of an 8:1, 3-bit mux: grants one
// requester, waits a settle time, captures mux_y and hands it off on valid/ready.
module mux_rr_scheduler #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [2:0] mux_y,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic [2:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int unsigned DWELL_EFF = (DWELL == 0) ? 1 : DWELL;
  localparam logic [7:0]  CNT_LOAD  = 8'(DWELL_EFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PRESENT
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] sel_nxt;
  logic [7:0] gnt_nxt;
  logic [2:0] data_nxt;
  logic       valid_nxt;

  logic [2:0] base;
  logic [2:0] win;
  logic       hit;

  // On a handshake edge ptr has not yet absorbed sel, so search from sel directly.
  always_comb begin
    base = (state == PRESENT) ? sel : ptr;
    win  = '0;
    hit  = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      if (!hit && req[base + 3'(k)]) begin
        win = base + 3'(k);
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    data_nxt  = out_data;
    valid_nxt = out_valid;

    case (state)
      IDLE: begin
        if (hit) begin
          sel_nxt   = win;
          gnt_nxt   = 8'b1 << win;
          cnt_nxt   = CNT_LOAD;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          data_nxt  = mux_y;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (out_valid && out_ready) begin
          ptr_nxt   = sel;
          valid_nxt = 1'b0;
          if (hit) begin
            sel_nxt   = win;
            gnt_nxt   = 8'b1 << win;
            cnt_nxt   = CNT_LOAD;
            state_nxt = SETTLE;
          end else begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '1;
      sel       <= '0;
      gnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      sel       <= sel_nxt;
      gnt       <= gnt_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule
